// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with frame-aligned shadow registers.
// Optional leading-zero suppression is enabled by defining SEG7_LZS_EN.

module seg7_digit (
  input  logic [3:0] nib_i,
  output logic [6:0] cath_o,
  output logic       nz_o
);
  always_comb begin
    cath_o = 7'h7F;
    unique case (nib_i)
      4'h0: cath_o = 7'h40;
      4'h1: cath_o = 7'h79;
      4'h2: cath_o = 7'h24;
      4'h3: cath_o = 7'h30;
      4'h4: cath_o = 7'h19;
      4'h5: cath_o = 7'h12;
      4'h6: cath_o = 7'h02;
      4'h7: cath_o = 7'h78;
      4'h8: cath_o = 7'h00;
      4'h9: cath_o = 7'h10;
      4'hA: cath_o = 7'h08;
      4'hB: cath_o = 7'h03;
      4'hC: cath_o = 7'h46;
      4'hD: cath_o = 7'h21;
      4'hE: cath_o = 7'h06;
      4'hF: cath_o = 7'h0E;
      default: cath_o = 7'h7F;
    endcase
  end

  assign nz_o = |nib_i;
endmodule

module seg7_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_we_i,
  input  logic        seg_sel_i,
  input  logic [31:0] seg_wdata_i,
  output logic [7:0]  seg_an_o,
  output logic [7:0]  seg_cath_o
);
  localparam int NUM_DIG = 8;
  localparam int DIV_W   = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  typedef struct packed {
    logic        we;
    logic        sel;
    logic [31:0] wdata;
  } seg_req_t;

  seg_req_t req;
  assign req = '{we: seg_we_i, sel: seg_sel_i, wdata: seg_wdata_i};

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      value_q, value_sh_q;
  logic [7:0]       mask_q, mask_sh_q;
  logic [7:0]       an_q, an_d, cath_q, cath_d;

  logic div_wrap, frame_end, blank, digit_on;

  logic [NUM_DIG-1:0][6:0] lane_cath;
  logic [NUM_DIG-1:0]      lane_nz;
  logic [NUM_DIG-1:0]      keep;

  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      seg7_digit u_dig (
        .nib_i  (value_sh_q[4*g +: 4]),
        .cath_o (lane_cath[g]),
        .nz_o   (lane_nz[g])
      );
    end
  endgenerate

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = div_q < DIV_W'(BLANK_CYC);
    end
  endgenerate

`ifdef SEG7_LZS_EN
  // A digit stays lit if it or any higher nibble is nonzero; digit 0 always lit.
  always_comb begin
    keep = '0;
    keep[NUM_DIG-1] = lane_nz[NUM_DIG-1];
    for (int i = NUM_DIG-2; i >= 0; i--) keep[i] = keep[i+1] | lane_nz[i];
    keep[0] = 1'b1;
  end
`else
  assign keep = '1;
`endif

  assign div_wrap  = (div_q == DIV_MAX);
  assign frame_end = div_wrap && (idx_q == 3'd7);

  always_comb begin
    div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
    idx_d    = div_wrap ? idx_q + 3'd1 : idx_q;
    digit_on = !blank && mask_sh_q[idx_q] && keep[idx_q];
    an_d     = 8'hFF;
    cath_d   = 8'hFF;
    if (digit_on) begin
      an_d   = ~(8'b1 << idx_q);
      cath_d = {1'b1, lane_cath[idx_q]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      value_q    <= '0;
      value_sh_q <= '0;
      mask_q     <= 8'hFF;
      mask_sh_q  <= 8'hFF;
      an_q       <= 8'hFF;
      cath_q     <= 8'hFF;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      cath_q <= cath_d;
      if (req.we && !req.sel) value_q <= req.wdata;
      if (req.we &&  req.sel) mask_q  <= req.wdata[7:0];
      // Shadow samples the pre-edge registers, so a write on this edge waits a frame.
      if (frame_end) begin
        value_sh_q <= value_q;
        mask_sh_q  <= mask_q;
      end
    end
  end

  assign seg_an_o   = an_q;
  assign seg_cath_o = cath_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at SCAN_DIV=4, BLANK_CYC=1 (slot = 4 cycles, frame = 32).
// Expected values follow SEG7_LZS_EN when it is defined for the build.

module tb_seg7_scan_driver;
  logic        clk, rst;
  logic        seg_we, seg_sel;
  logic [31:0] seg_wdata;
  logic [7:0]  seg_an, seg_cath;

  int checks = 0;
  int errors = 0;
  int cyc;

`ifdef SEG7_LZS_EN
  localparam bit LZS = 1'b1;
`else
  localparam bit LZS = 1'b0;
`endif

  seg7_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_we_i    (seg_we),
    .seg_sel_i   (seg_sel),
    .seg_wdata_i (seg_wdata),
    .seg_an_o    (seg_an),
    .seg_cath_o  (seg_cath)
  );

  always #5 clk = ~clk;

  // Edges since reset release; pins after edge n reflect scan state n-1.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int          cyc;
    logic [7:0]  an;
    logic [7:0]  cath;
    bit          wr;
    bit          sel;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string nm, input logic [7:0] an, input logic [7:0] cath);
    checks++;
    if (seg_an !== an || seg_cath !== cath) begin
      errors++;
      $display("FAIL %s: an=%h cath=%h, want an=%h cath=%h", nm, seg_an, seg_cath, an, cath);
    end
  endtask

  task automatic step_to(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != target) begin
      checks++;
      errors++;
      $display("FAIL step_to: cyc=%0d, want %0d", cyc, target);
    end
  endtask

  task automatic wr(input bit sel, input logic [31:0] d);
    seg_we    = 1'b1;
    seg_sel   = sel;
    seg_wdata = d;
    @(posedge clk);
    #1;
    seg_we    = 1'b0;
    seg_sel   = 1'b0;
    seg_wdata = '0;
  endtask

  task automatic set(input int i, input int c, input logic [7:0] an, input logic [7:0] cath,
                     input bit w, input bit s, input logic [31:0] d);
    tbl[i] = '{cyc: c, an: an, cath: cath, wr: w, sel: s, wd: d};
  endtask

  task automatic run_vec(input int i);
    step_to(tbl[i].cyc);
    chk($sformatf("vec%0d@cyc%0d", i, tbl[i].cyc), tbl[i].an, tbl[i].cath);
    if (tbl[i].wr) wr(tbl[i].sel, tbl[i].wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then power-on value 0 with all digits enabled.
    set(0,  1,   8'hFF, 8'hFF, 1'b0, 1'b0, 32'h0);
    set(1,  2,   8'hFE, 8'hC0, 1'b1, 1'b0, 32'h12345678);
    set(2,  19,  LZS ? 8'hFF : 8'hEF, LZS ? 8'hFF : 8'hC0, 1'b0, 1'b0, 32'h0);
    // Frame 1: 12345678 from the shadow.
    set(3,  34,  8'hFE, 8'h80, 1'b0, 1'b0, 32'h0);
    set(4,  47,  8'hF7, 8'h92, 1'b0, 1'b0, 32'h0);
    set(5,  50,  8'hEF, 8'h99, 1'b0, 1'b0, 32'h0);
    set(6,  64,  8'h7F, 8'hF9, 1'b0, 1'b0, 32'h0);
    // Frame 2: mask 0F written, still full mask this frame.
    set(7,  66,  8'hFE, 8'h80, 1'b1, 1'b1, 32'h0000000F);
    set(8,  91,  8'hBF, 8'hA4, 1'b0, 1'b0, 32'h0);
    // Frame 3: upper digits masked; restore mask mid-frame.
    set(9,  108, 8'hFB, 8'h82, 1'b1, 1'b1, 32'h000000FF);
    set(10, 119, 8'hFF, 8'hFF, 1'b0, 1'b0, 32'h0);
    set(11, 126, 8'hFF, 8'hFF, 1'b0, 1'b0, 32'h0);
    // Frame 4: write FFFFFFFF at idx 3; digits 4..7 keep old value.
    set(12, 142, 8'hF7, 8'h92, 1'b1, 1'b0, 32'hFFFFFFFF);
    set(13, 150, 8'hDF, 8'hB0, 1'b0, 1'b0, 32'h0);
    set(14, 159, 8'h7F, 8'hF9, 1'b0, 1'b0, 32'h0);
    // Frame 6: boundary write of 0 not yet visible.
    set(15, 194, 8'hFE, 8'h8E, 1'b0, 1'b0, 32'h0);
    set(16, 224, 8'h7F, 8'h8E, 1'b0, 1'b0, 32'h0);
    // Frame 7: value 0 visible; then load 000000A0.
    set(17, 226, 8'hFE, 8'hC0, 1'b0, 1'b0, 32'h0);
    set(18, 254, LZS ? 8'hFF : 8'h7F, LZS ? 8'hFF : 8'hC0, 1'b1, 1'b0, 32'h000000A0);
    // Frame 8: 000000A0.
    set(19, 258, 8'hFE, 8'hC0, 1'b0, 1'b0, 32'h0);
    set(20, 263, 8'hFD, 8'h88, 1'b0, 1'b0, 32'h0);
    set(21, 268, LZS ? 8'hFF : 8'hFB, LZS ? 8'hFF : 8'hC0, 1'b0, 1'b0, 32'h0);
    set(22, 288, LZS ? 8'hFF : 8'h7F, LZS ? 8'hFF : 8'hC0, 1'b0, 1'b0, 32'h0);

    clk = 1'b0; rst = 1'b1;
    seg_we = 1'b0; seg_sel = 1'b0; seg_wdata = '0;
    #1;
    chk("reset_state", 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Mid-slot reset: pins blank at once, before any clock edge.
    step_to(10);
    chk("pre_reset_d2", LZS ? 8'hFF : 8'hFB, LZS ? 8'hFF : 8'hC0);
    #2 rst = 1'b1;
    #1 chk("async_reset", 8'hFF, 8'hFF);
    repeat (2) @(posedge clk);
    #1 chk("reset_held", 8'hFF, 8'hFF);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i <= 14; i++) run_vec(i);

    // Frame 5: every slot blank on its first cycle, single low anode after.
    for (int c = 161; c <= 191; c++) begin
      int s;
      logic [7:0] ea, ec;
      step_to(c);
      s  = c - 1;
      ea = (s % 4 == 0) ? 8'hFF : ~(8'h01 << ((s / 4) % 8));
      ec = (s % 4 == 0) ? 8'hFF : 8'h8E;
      chk($sformatf("blank_sweep@cyc%0d", c), ea, ec);
    end
    // Issued after edge 191, captured on boundary edge 192.
    wr(1'b0, 32'h0);

    for (int i = 15; i <= 22; i++) run_vec(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
